mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//    Shares one single-port RAM (1-cycle registered read, byte-masked write)
//    between two requesters: port 0 = instruction fetch, port 1 = load/store.
//    It accepts one access at a time, latches the winning request, drives the
//    RAM for one cycle and returns read data with a one-cycle ready pulse.
//
// Ports:
//    clk, reset        system clock; synchronous active-high reset
//    pN_req            port N request (held until pN_ready)
//    pN_addr           port N byte address, passed to the RAM unmodified
//    pN_wdata          port N write data
//    pN_wmask          port N byte enables, all-zero means read
//    pN_rdata          port N read data, valid with pN_ready and held after
//    pN_ready          port N one-cycle completion pulse
//    mem_addr/wdata    RAM address / write data (hold last value when idle)
//    mem_wmask         RAM byte write enables, nonzero only in ISSUE
//    mem_rstrb         RAM read strobe, high only in ISSUE for a read
//    mem_rdata         RAM read data, valid the cycle after mem_rstrb
//    busy              high while a transaction is in ISSUE or WAIT
//    grant             one-hot owner of the current transaction, 0 when idle
//    o_dbg_state       current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
//
// Configuration:
//    MEM_ARB_ROUND_ROBIN_EN  defined   : round-robin priority on a tie
//                            undefined : fixed priority, port 1 beats port 0
//
// Handshake: a requester raises pN_req with stable addr/wdata/wmask and holds
// it until it sees pN_ready high; on the clock edge that samples pN_ready it
// either drops pN_req or presents the next request. A req still high in IDLE
// after its ready is taken as a new request. The owner's req is ignored in
// WAIT, so holding it across the ready edge never double-issues in WAIT.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                p0_req,
   input  logic [ADDR_W-1:0]   p0_addr,
   input  logic [DATA_W-1:0]   p0_wdata,
   input  logic [DATA_W/8-1:0] p0_wmask,
   output logic [DATA_W-1:0]   p0_rdata,
   output logic                p0_ready,
   input  logic                p1_req,
   input  logic [ADDR_W-1:0]   p1_addr,
   input  logic [DATA_W-1:0]   p1_wdata,
   input  logic [DATA_W/8-1:0] p1_wmask,
   output logic [DATA_W-1:0]   p1_rdata,
   output logic                p1_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   output logic                mem_rstrb,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic [1:0]          grant,
   output logic [1:0]          o_dbg_state
);

   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [MASK_W-1:0]   r_wmask;      // latched mask, kept through WAIT
   logic                r_id;         // owner: 0 = port 0, 1 = port 1
   logic [1:0]          r_grant;
   logic                r_busy;
   logic                r_rstrb;
   logic [MASK_W-1:0]   r_mem_wmask;  // mask driven to RAM, ISSUE only
   logic                r_p0_ready;
   logic                r_p1_ready;
   logic [DATA_W-1:0]   r_p0_rdata;
   logic [DATA_W-1:0]   r_p1_rdata;

   logic                w_pick1;
   logic                w_load;
   logic                w_load_id;
   logic [ADDR_W-1:0]   w_ld_addr;
   logic [DATA_W-1:0]   w_ld_wdata;
   logic [MASK_W-1:0]   w_ld_wmask;
   logic                w_is_read;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic                r_rr_last;

   // On a tie the port that was not granted last wins.
   assign w_pick1 = p1_req & (~p0_req | ~r_rr_last);

   // Tracks the owner of every transaction entering ISSUE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_last <= 1'b0;
      end else if (w_load) begin
         r_rr_last <= w_load_id;
      end
   end
`else
   assign w_pick1 = p1_req;
`endif

   // Decide whether a request enters ISSUE at the next edge and from which port.
   // From WAIT only the other port can be chained back-to-back.
   always_comb begin
      w_load    = 1'b0;
      w_load_id = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_load    = p0_req | p1_req;
            w_load_id = w_pick1;
         end
         ST_WAIT: begin
            w_load    = r_id ? p0_req : p1_req;
            w_load_id = ~r_id;
         end
         default: begin
            w_load    = 1'b0;
            w_load_id = 1'b0;
         end
      endcase
   end

   assign w_ld_addr  = w_load_id ? p1_addr  : p0_addr;
   assign w_ld_wdata = w_load_id ? p1_wdata : p0_wdata;
   assign w_ld_wmask = w_load_id ? p1_wmask : p0_wmask;
   assign w_is_read  = (r_wmask == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wmask     <= '0;
         r_id        <= 1'b0;
         r_grant     <= 2'b00;
         r_busy      <= 1'b0;
         r_rstrb     <= 1'b0;
         r_mem_wmask <= '0;
         r_p0_ready  <= 1'b0;
         r_p1_ready  <= 1'b0;
         r_p0_rdata  <= '0;
         r_p1_rdata  <= '0;
      end else begin
         // Strobes and ready are single-cycle pulses.
         r_rstrb     <= 1'b0;
         r_mem_wmask <= '0;
         r_p0_ready  <= 1'b0;
         r_p1_ready  <= 1'b0;

         case (r_state)
            ST_ISSUE: begin
               r_state    <= ST_WAIT;
               r_p0_ready <= ~r_id;
               r_p1_ready <= r_id;
            end
            ST_WAIT: begin
               // Keep a copy so rdata stays valid after the ready pulse.
               if (w_is_read) begin
                  if (r_id) begin
                     r_p1_rdata <= mem_rdata;
                  end else begin
                     r_p0_rdata <= mem_rdata;
                  end
               end
               if (!w_load) begin
                  r_state <= ST_IDLE;
                  r_grant <= 2'b00;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         // Entering ISSUE (from IDLE or back-to-back from WAIT).
         if (w_load) begin
            r_state     <= ST_ISSUE;
            r_addr      <= w_ld_addr;
            r_wdata     <= w_ld_wdata;
            r_wmask     <= w_ld_wmask;
            r_id        <= w_load_id;
            r_grant     <= w_load_id ? 2'b10 : 2'b01;
            r_busy      <= 1'b1;
            r_rstrb     <= (w_ld_wmask == '0);
            r_mem_wmask <= w_ld_wmask;
         end
      end
   end

   // Reset gates the strobes and ready pulses in the same cycle so a
   // transaction interrupted by reset never touches the RAM or completes.
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign mem_rstrb   = r_rstrb & ~reset;
   assign mem_wmask   = r_mem_wmask & {MASK_W{~reset}};
   assign p0_ready    = r_p0_ready & ~reset;
   assign p1_ready    = r_p1_ready & ~reset;
   assign busy        = r_busy;
   assign grant       = r_grant;
   assign o_dbg_state = r_state;

   // RAM data arrives in the ready cycle itself; afterwards the registered copy
   // is shown. Writes never expose mem_rdata.
   assign p0_rdata = (p0_ready && w_is_read) ? mem_rdata : r_p0_rdata;
   assign p1_rdata = (p1_ready && w_is_read) ? mem_rdata : r_p1_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter: a behavioural RAM hangs off the memory side, a
// transaction-level reference memory predicts read data per port, directed
// sequences pin down timing and priority, then two random requesters run
// concurrently on disjoint address ranges.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        p0_req, p1_req;
   logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata, p0_rdata, p1_rdata;
   logic [3:0]  p0_wmask, p1_wmask;
   logic        p0_ready, p1_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb;
   logic        busy;
   logic [1:0]  grant;
   logic [1:0]  o_dbg_state;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
      .p0_rdata(p0_rdata), .p0_ready(p0_ready),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
      .p1_rdata(p1_rdata), .p1_ready(p1_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
      .busy(busy), .grant(grant), .o_dbg_state(o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk) cyc++;

   // ---------------- behavioural RAM ----------------
   logic [31:0] ram     [0:255];
   logic [31:0] ref_mem [0:255];
   bit          ram_ready;

   function automatic logic [31:0] init_word(input int i);
      if (i == 0) return 32'h0000_0013;
      return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
         ram_ready <= 1'b1;
      end else begin
         if (mem_rstrb) mem_rdata <= ram[mem_addr[9:2]];
         if (mem_wmask != 4'b0)
            ram[mem_addr[9:2]] <= merge(ram[mem_addr[9:2]], mem_wdata, mem_wmask);
      end
   end

   // ---------------- scoreboard ----------------
   // Entry = {is_read, expected read data}
   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   int n_checks;
   int n_pass;
   int rdy_cnt[2];
   int last_rdy_cyc[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic mon_port(input int p, input logic [31:0] rd);
      logic [32:0] e;
      int          sz;
      rdy_cnt[p]++;
      last_rdy_cyc[p] = cyc;
      check(p ? "p1_grant_at_ready" : "p0_grant_at_ready", 32'(grant), p ? 32'd2 : 32'd1);
      sz = p ? exp_q1.size() : exp_q0.size();
      check(p ? "p1_ready_pending" : "p0_ready_pending", 32'(sz > 0), 1);
      if (sz > 0) begin
         e = p ? exp_q1.pop_front() : exp_q0.pop_front();
         if (e[32]) check(p ? "p1_rdata" : "p0_rdata", rd, e[31:0]);
      end
   endtask

   always @(negedge clk) begin
      if (p0_ready || p1_ready) check("one_ready_only", 32'(p0_ready & p1_ready), 0);
      if (p0_ready) mon_port(0, p0_rdata);
      if (p1_ready) mon_port(1, p1_rdata);
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input int p, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m);
      if (p == 0) begin
         p0_req = r; p0_addr = a; p0_wdata = d; p0_wmask = m;
      end else begin
         p1_req = r; p1_addr = a; p1_wdata = d; p1_wmask = m;
      end
   endtask

   // Predict the outcome from the reference memory in program order per port.
   task automatic push_exp(input int p, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
      logic [32:0] e;
      e = {(m == 4'b0), ref_mem[a[9:2]]};
      if (m != 4'b0) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, m);
      if (p == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   // Waits (bounded) until port p has seen a ready beyond start_cnt; returns its cycle.
   task automatic wait_rdy(input int p, input int start_cnt, output int t);
      t = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk); #1;
         if (rdy_cnt[p] > start_cnt) begin
            t = last_rdy_cyc[p];
            break;
         end
      end
      check(p ? "p1_ready_seen" : "p0_ready_seen", 32'(rdy_cnt[p] > start_cnt), 1);
   endtask

   task automatic txn(input int p, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input int exp_lat, input string tag);
      int s, c0, t;
      push_exp(p, a, d, m);
      c0 = rdy_cnt[p];
      set_req(p, 1'b1, a, d, m);
      s = cyc;
      wait_rdy(p, c0, t);
      check(tag, 32'(t - s), 32'(exp_lat));
      @(posedge clk); #1;
      set_req(p, 1'b0, a, d, m);
   endtask

   // Single access with cycle-exact checks of the memory side.
   task automatic single_chk(input int p, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] m, input string tag);
      logic [1:0] g;
      g = (p == 1) ? 2'b10 : 2'b01;
      push_exp(p, a, d, m);
      set_req(p, 1'b1, a, d, m);
      @(negedge clk);
      check({tag, "_no_early_strobe"}, 32'({mem_rstrb, mem_wmask}), 0);
      @(negedge clk);
      check({tag, "_rstrb"}, 32'(mem_rstrb), 32'(m == 4'b0));
      check({tag, "_wmask"}, 32'(mem_wmask), 32'(m));
      check({tag, "_addr"}, mem_addr, a);
      check({tag, "_grant"}, 32'(grant), 32'(g));
      check({tag, "_busy"}, 32'(busy), 1);
      if (m != 4'b0) check({tag, "_wdata"}, mem_wdata, d);
      @(negedge clk);
      check({tag, "_ready"}, 32'((p == 1) ? p1_ready : p0_ready), 1);
      check({tag, "_strobe_gone"}, 32'({mem_rstrb, mem_wmask}), 0);
      @(posedge clk); #1;
      set_req(p, 1'b0, a, d, m);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   task automatic test_reset_state();
      @(negedge clk);
      check("rst_grant_busy", 32'({grant, busy}), 0);
      check("rst_ready", 32'({p0_ready, p1_ready}), 0);
      check("rst_mem_strobes", 32'({mem_rstrb, mem_wmask}), 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_p0_rdata", p0_rdata, 0);
      check("rst_p1_rdata", p1_rdata, 0);
      check("rst_state", 32'(o_dbg_state), 0);
      @(posedge clk); #1;
   endtask

   task automatic test_simultaneous();
      int s, c0, c1, t0, t1, first;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      first = 0;   // port 1 was granted last
`else
      first = 1;
`endif
      push_exp(0, 32'h0000_0008, 0, 4'b0);
      push_exp(1, 32'h0000_0194, 0, 4'b0);
      c0 = rdy_cnt[0];
      c1 = rdy_cnt[1];
      set_req(0, 1'b1, 32'h0000_0008, 0, 4'b0);
      set_req(1, 1'b1, 32'h0000_0194, 0, 4'b0);
      s = cyc;
      fork
         begin
            wait_rdy(0, c0, t0);
            @(posedge clk); #1;
            set_req(0, 1'b0, 0, 0, 4'b0);
         end
         begin
            wait_rdy(1, c1, t1);
            @(posedge clk); #1;
            set_req(1, 1'b0, 0, 0, 4'b0);
         end
      join
      check("sim_p0_latency", 32'(t0 - s), (first == 0) ? 32'd2 : 32'd4);
      check("sim_p1_latency", 32'(t1 - s), (first == 1) ? 32'd2 : 32'd4);
   endtask

   task automatic test_continuous();
      int c0, c1;
      logic [1:0] g;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      g = 2'b01;
`else
      g = 2'b10;
`endif
      for (int i = 0; i < 5; i++) begin
         push_exp(0, 32'h0000_0010, 0, 4'b0);
         push_exp(1, 32'h0000_0110, 0, 4'b0);
      end
      c0 = rdy_cnt[0];
      c1 = rdy_cnt[1];
      set_req(0, 1'b1, 32'h0000_0010, 0, 4'b0);
      set_req(1, 1'b1, 32'h0000_0110, 0, 4'b0);
      for (int k = 0; k < 22; k++) begin
         @(negedge clk);
         if (p0_ready || p1_ready) begin
            check("cont_grant_order", 32'(grant), 32'(g));
            g = {g[0], g[1]};
         end
         @(posedge clk); #1;
         if (k == 19) begin
            set_req(0, 1'b0, 0, 0, 4'b0);
            set_req(1, 1'b0, 0, 0, 4'b0);
         end
      end
      check("cont_p0_readies", 32'(rdy_cnt[0] - c0), 5);
      check("cont_p1_readies", 32'(rdy_cnt[1] - c1), 5);
   endtask

   task automatic test_reset_in_wait();
      int c0;
      push_exp(0, 32'h0000_0020, 0, 4'b0);
      c0 = rdy_cnt[0];
      set_req(0, 1'b1, 32'h0000_0020, 0, 4'b0);
      @(posedge clk); #1;           // ISSUE
      @(posedge clk); #1;           // WAIT
      reset = 1'b1;
      set_req(0, 1'b0, 0, 0, 4'b0);
      @(negedge clk);
      check("rstwait_no_ready", 32'(p0_ready), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rstwait_state_idle", 32'(o_dbg_state), 0);
      check("rstwait_grant_busy", 32'({grant, busy}), 0);
      exp_q0.delete();
      repeat (3) @(posedge clk);
      #1;
      check("rstwait_no_late_ready", 32'(rdy_cnt[0] - c0), 0);
      txn(0, 32'h0000_0020, 0, 4'b0, 2, "rstwait_reissue_latency");
   endtask

   task automatic test_held_req();
      int s, c0, c1, t;
      push_exp(0, 32'h0000_0024, 0, 4'b0);
      push_exp(0, 32'h0000_0024, 0, 4'b0);
      c0 = rdy_cnt[0];
      c1 = rdy_cnt[1];
      set_req(0, 1'b1, 32'h0000_0024, 0, 4'b0);
      s = cyc;
      wait_rdy(0, c0, t);
      check("held_first_latency", 32'(t - s), 2);
      @(posedge clk); #1;           // req still high in this cycle
      @(posedge clk); #1;
      set_req(0, 1'b0, 0, 0, 4'b0);
      wait_rdy(0, c0 + 1, t);
      check("held_second_latency", 32'(t - s), 5);
      repeat (4) @(posedge clk);
      #1;
      check("held_p0_readies", 32'(rdy_cnt[0] - c0), 2);
      check("held_p1_quiet", 32'(rdy_cnt[1] - c1), 0);
   endtask

   // ---------------- random requesters ----------------
   task automatic rand_driver(input int p, input int n);
      int s, c, t, gap;
      logic [31:0] a, d;
      logic [3:0]  m;
      for (int i = 0; i < n; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            @(posedge clk); #1;
         end
         a = 32'(((p == 1) ? 64 : 0) + $urandom_range(0, 31)) << 2;
         d = $urandom;
         m = ($urandom_range(0, 1) == 1) ? 4'b0 : 4'($urandom_range(1, 15));
         push_exp(p, a, d, m);
         c = rdy_cnt[p];
         set_req(p, 1'b1, a, d, m);
         s = cyc;
         wait_rdy(p, c, t);
         check(p ? "rnd_p1_latency_in_2_4" : "rnd_p0_latency_in_2_4",
               32'((t - s >= 2) && (t - s <= 4)), 1);
         @(posedge clk); #1;
         set_req(p, 1'b0, a, d, m);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      set_req(0, 1'b0, 0, 0, 4'b0);
      set_req(1, 1'b0, 0, 0, 4'b0);
      do_reset(3);
      test_reset_state();

      single_chk(0, 32'h0000_0000, 0, 4'b0, "p0_read0");
      check("p0_read0_rdata_held", p0_rdata, 32'h0000_0013);

      single_chk(1, 32'h0000_0190, 32'h0000_00AA, 4'b0001, "p1_write");
      txn(1, 32'h0000_0190, 0, 4'b0, 2, "p1_readback_latency");
      check("p1_readback_byte", 32'(p1_rdata[7:0]), 32'h0000_00AA);

      test_simultaneous();
      test_continuous();
      test_reset_in_wait();
      test_held_req();

      fork
         rand_driver(0, 30);
         rand_driver(1, 30);
      join
      repeat (4) @(posedge clk);
      #1;
      check("q0_drained", 32'(exp_q0.size()), 0);
      check("q1_drained", 32'(exp_q1.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
